word_aligner: RTL
=================

# word_aligner

Byte-level word aligner that sits directly downstream of the data recovery unit. It accepts the 0–2 recovered bits per cycle produced by the DRU and hunts for a sync word at bit granularity. Once the sync word repeats at a consistent boundary it declares lock and emits aligned parallel words with a one-cycle valid strobe. It runs entirely in the DRU's `clk_100` domain.

## Interface
- `WORD_W`, 8: word width in bits; must be ≥ 4.
- `SYNC_WORD`, 8'hD5: alignment pattern, MSB received first.
- `SYNC_COUNT`, 2: consecutive on-boundary sync matches required to lock; must be ≥ 1.
- `IDLE_CYCLES`, 64: idle timeout length in cycles. Used only with `WORD_ALIGNER_IDLE_TIMEOUT_EN`.
- `clk` in 1: the single clock, same as DRU `clk`.
- `aresetn` in 1: synchronous, active-low reset. Sampled on the rising edge of `clk`.
- `bits_in` in 2: recovered bits. `bits_in[0]` is received first, `bits_in[1]` second.
- `bits_cnt` in 2: number of valid bits in `bits_in`. Legal values are 0, 1, 2. Value 3 is illegal and the cycle is ignored completely.
- `word_out` out WORD_W: aligned word, first-received bit in the MSB.
- `word_valid` out 1: one-cycle strobe qualifying `word_out`.
- `locked` out 1: high while in LOCKED.

## Operation
- Shift register `sr[WORD_W-1:0]` shifts left; each new bit enters the LSB.
- When `bits_cnt` is 2, bits are inserted in order `bits_in[0]`, then `bits_in[1]`. Every per-bit check below is evaluated after each individual insertion, including the intermediate one.
- `fill` counts bits since entering HUNT, saturating at WORD_W. A match in HUNT requires `fill` = WORD_W.
- `bitpos` (0..WORD_W-1) counts bits within the current word once a boundary is set.
- States:
  - HUNT. After each bit, if `fill` = WORD_W and `sr` = SYNC_WORD, the boundary is set at that bit:
    - `bitpos` is set to 0 and `hits` to 1.
    - If SYNC_COUNT = 1, go to LOCKED; otherwise go to CHECK.
    - If the match occurs on the first of two bits in a cycle, the second bit is bit 0 of the next word.
  - CHECK. Each bit increments `bitpos`. On word completion (the WORD_W-th bit):
    - `sr` = SYNC_WORD: increment `hits`. Reaching SYNC_COUNT moves to LOCKED; otherwise stay in CHECK.
    - `sr` ≠ SYNC_WORD: go to HUNT, clearing `fill` and `hits`.
  - LOCKED. Every completed word loads `word_out` = `sr` and pulses `word_valid`. Sync words are output like data.
  - The word that completes the lock is not output.
- At most one word completes per cycle, because WORD_W ≥ 4.
- In LOCKED there is no exit except reset, or the idle timeout when that feature is compiled in.

## Timing
- Reset values:
  - `word_out` = 0, `word_valid` = 0, `locked` = 0.
  - `sr` = 0, `fill` = 0, `bitpos` = 0, `hits` = 0, state HUNT.
- Reset takes effect at the first rising edge with `aresetn` = 0. Reset mid-word discards the partial word, and no `word_valid` is issued on that edge.
- Latency: if the input sampled at edge N completes a word in LOCKED, `word_out` and `word_valid` are valid after edge N. This is one registered stage; `word_valid` falls after edge N+1 unless another word completes.
- `locked` rises after the edge at which the final sync match is accepted. It falls after the edge that causes a transition to HUNT.
- `bits_cnt` = 0 or 3: no state change and no bit insertion.
- `word_out` holds its last value between strobes.

## Configuration
- `WORD_ALIGNER_IDLE_TIMEOUT_EN`:
  - Defined: an idle counter increments on each cycle with `bits_cnt` = 0 in CHECK or LOCKED and clears on any cycle carrying bits.
    - On reaching IDLE_CYCLES, the state goes to HUNT on that edge, clearing `fill`, `hits` and `locked`. No `word_valid` is issued.
    - The counter is held at 0 in HUNT.
  - Not defined: no idle counter, and CHECK and LOCKED never time out.

## Test plan
- 1 bit/cycle stream D5, D5, A3, 3C (defaults) → `locked` rises after the 16th bit; `word_valid` pulses exactly twice, with `word_out` = A3 then 3C, 8 cycles apart.
- Same stream at 2 bits/cycle, preceded by one junk bit so the sync match falls on `bits_in[0]` → lock still achieved; outputs are A3, 3C with a 4-cycle spacing.
- D5 followed by 5A (mismatch in CHECK), then D5, D5, 77 → return to HUNT after the 5A word; lock after the third D5 is complete; first output is 77.
- `bits_cnt` = 3 and `bits_cnt` = 0 cycles interleaved in a locked stream → ignored; the output words are identical to the stream without them.
- `aresetn` = 0 for one cycle midway through a locked word → all outputs 0 and `locked` = 0 after that edge; relock requires SYNC_COUNT new sync words.
- With `WORD_ALIGNER_IDLE_TIMEOUT_EN` and IDLE_CYCLES = 64, locked, then 64 cycles of `bits_cnt` = 0 → `locked` falls after the 64th idle edge. With 63 idle cycles, lock is kept.

Source files
------------

// File: rtl/word_aligner.sv
// Bit-serial sync-word hunter: accepts 0-2 recovered bits per cycle and emits aligned words once locked.
// Optional idle timeout out of CHECK/LOCKED is compiled in with `define WORD_ALIGNER_IDLE_TIMEOUT_EN.
module word_aligner #(
   parameter int                WORD_W      = 8,
   parameter logic [WORD_W-1:0] SYNC_WORD   = 8'hD5,
   parameter int                SYNC_COUNT  = 2,
   parameter int                IDLE_CYCLES = 64
) (
   input  logic              clk,
   input  logic              aresetn,
   input  logic [1:0]        bits_in,
   input  logic [1:0]        bits_cnt,
   output logic [WORD_W-1:0] word_out,
   output logic              word_valid,
   output logic              locked
);

   localparam int FILL_W = $clog2(WORD_W + 1);
   localparam int POS_W  = $clog2(WORD_W);
   localparam int HITS_W = $clog2(SYNC_COUNT + 1);

   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WORD_W);
   localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(WORD_W - 1);
   localparam logic [HITS_W-1:0] HITS_LOCK = HITS_W'(SYNC_COUNT);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   typedef struct packed {
      state_t              state;
      logic [WORD_W-1:0]   sr;
      logic [FILL_W-1:0]   fill;
      logic [POS_W-1:0]    bitpos;
      logic [HITS_W-1:0]   hits;
      logic                emit;
      logic [WORD_W-1:0]   word;
   } st_t;

   if (WORD_W < 4 || SYNC_COUNT < 1 || IDLE_CYCLES < 1) begin : g_bad_param
      $error("word_aligner: illegal parameter value");
   end

   // Advances the aligner by exactly one received bit; applied twice for two-bit cycles.
   function automatic st_t step(input st_t s, input logic b);
      st_t n;
      n    = s;
      n.sr = {s.sr[WORD_W-2:0], b};
      case (s.state)
         HUNT: begin
            if (s.fill != FILL_FULL) begin
               n.fill = s.fill + 1'b1;
            end
            if (n.fill == FILL_FULL && n.sr == SYNC_WORD) begin
               n.bitpos = '0;
               n.hits   = HITS_W'(1);
               n.state  = (SYNC_COUNT == 1) ? LOCKED : CHECK;
            end
         end
         CHECK: begin
            if (s.bitpos == POS_LAST) begin
               n.bitpos = '0;
               if (n.sr == SYNC_WORD) begin
                  n.hits = s.hits + 1'b1;
                  if (n.hits == HITS_LOCK) begin
                     n.state = LOCKED;
                  end
               end else begin
                  n.state = HUNT;
                  n.fill  = '0;
                  n.hits  = '0;
               end
            end else begin
               n.bitpos = s.bitpos + 1'b1;
            end
         end
         LOCKED: begin
            if (s.bitpos == POS_LAST) begin
               n.bitpos = '0;
               n.emit   = 1'b1;
               n.word   = n.sr;
            end else begin
               n.bitpos = s.bitpos + 1'b1;
            end
         end
         default: ;
      endcase
      return n;
   endfunction

   state_t              r_state;
   logic [WORD_W-1:0]   r_sr;
   logic [FILL_W-1:0]   r_fill;
   logic [POS_W-1:0]    r_bitpos;
   logic [HITS_W-1:0]   r_hits;
   logic [WORD_W-1:0]   r_word_out;
   logic                r_word_valid;
   logic                r_locked;

   st_t  w_cur;
   st_t  w_st1;
   st_t  w_st2;
   logic w_has_bits;

   assign w_cur = '{state: r_state, sr: r_sr, fill: r_fill, bitpos: r_bitpos,
                    hits: r_hits, emit: 1'b0, word: '0};
   assign w_st1      = step(w_cur, bits_in[0]);
   assign w_st2      = (bits_cnt == 2'd2) ? step(w_st1, bits_in[1]) : w_st1;
   assign w_has_bits = (bits_cnt == 2'd1) || (bits_cnt == 2'd2);

`ifdef WORD_ALIGNER_IDLE_TIMEOUT_EN
   localparam int               IDLE_W    = $clog2(IDLE_CYCLES + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
   logic [IDLE_W-1:0] r_idle;
`endif

   always_ff @(posedge clk) begin
      if (!aresetn) begin
         r_state      <= HUNT;
         r_sr         <= '0;
         r_fill       <= '0;
         r_bitpos     <= '0;
         r_hits       <= '0;
         r_word_out   <= '0;
         r_word_valid <= 1'b0;
         r_locked     <= 1'b0;
`ifdef WORD_ALIGNER_IDLE_TIMEOUT_EN
         r_idle       <= '0;
`endif
      end else begin
         r_word_valid <= 1'b0;
         // bits_cnt of 0 or 3 leaves the bit-tracking state untouched
         if (w_has_bits) begin
            r_state  <= w_st2.state;
            r_sr     <= w_st2.sr;
            r_fill   <= w_st2.fill;
            r_bitpos <= w_st2.bitpos;
            r_hits   <= w_st2.hits;
            r_locked <= (w_st2.state == LOCKED);
            if (w_st2.emit) begin
               r_word_out   <= w_st2.word;
               r_word_valid <= 1'b1;
            end
`ifdef WORD_ALIGNER_IDLE_TIMEOUT_EN
            r_idle <= '0;
         end else if (bits_cnt == 2'd0 && r_state != HUNT) begin
            if (r_idle == IDLE_LAST) begin
               r_state  <= HUNT;
               r_fill   <= '0;
               r_hits   <= '0;
               r_locked <= 1'b0;
               r_idle   <= '0;
            end else begin
               r_idle <= r_idle + 1'b1;
            end
`endif
         end
      end
   end

   assign word_out   = r_word_out;
   assign word_valid = r_word_valid;
   assign locked     = r_locked;

endmodule
